// File: rtl/interp_pkg.sv
// Shared types and constants for the interpolation coordinate generator.
// Holds the default coordinate width, FSM state type and step operands.
package interp_pkg;

    localparam int COORD_W_DEF = 8;

    localparam int STEP_ONE  = 1;
    localparam int STEP_ZERO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/coord_axis_counter.sv
// Bounded axis counter: clears on load, steps on enable, wraps past max_i.
// nxt_o exposes the value the counter takes at the next rising edge.
module coord_axis_counter
    import interp_pkg::*;
#(
    parameter int W = COORD_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] max_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] nxt_o,
    output logic         at_max_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign at_max_o = (cnt_q == max_i);
    assign cnt_o    = cnt_q;
    assign nxt_o    = cnt_d;

    // Next count: clear wins, otherwise step and wrap at the bound.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = at_max_o ? '0 : cnt_q + W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/interp_coord_gen.sv
// Raster-order source-coordinate generator with valid/ready output.
// Define INTERP_COORD_GEN_EDGE_CLAMP_EN to clamp steps at the grid edge.
module interp_coord_gen
    import interp_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COORD_W-1:0] width_m1,
    input  logic [COORD_W-1:0] height_m1,
    output logic               busy,
    output logic               done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COORD_W-1:0] step_x,
    output logic [COORD_W-1:0] step_y,
    output logic               last
);

    state_e             state_q;
    logic [COORD_W-1:0] wm1_q;
    logic [COORD_W-1:0] hm1_q;
    logic [COORD_W-1:0] step_x_q;
    logic [COORD_W-1:0] step_y_q;
    logic [COORD_W-1:0] step_x_d;
    logic [COORD_W-1:0] step_y_d;
    logic               busy_q;
    logic               done_q;
    logic               valid_q;
    logic               last_q;
    logic               last_d;

    logic               start_acc;
    logic               xfer;
    logic               frame_end;
    logic               x_at_max;
    logic               y_at_max;
    logic [COORD_W-1:0] x_cnt;
    logic [COORD_W-1:0] y_cnt;
    logic [COORD_W-1:0] x_nxt;
    logic [COORD_W-1:0] y_nxt;
    logic [COORD_W-1:0] bound_x_d;
    logic [COORD_W-1:0] bound_y_d;

    assign start_acc = (state_q == ST_IDLE) && start;
    assign xfer      = valid_q && out_ready;
    assign frame_end = xfer && x_at_max && y_at_max;

    coord_axis_counter #(
        .W (COORD_W)
    ) u_x_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (start_acc),
        .inc_i    (xfer),
        .max_i    (wm1_q),
        .cnt_o    (x_cnt),
        .nxt_o    (x_nxt),
        .at_max_o (x_at_max)
    );

    coord_axis_counter #(
        .W (COORD_W)
    ) u_y_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (start_acc),
        .inc_i    (xfer && x_at_max),
        .max_i    (hm1_q),
        .cnt_o    (y_cnt),
        .nxt_o    (y_nxt),
        .at_max_o (y_at_max)
    );

    // Bounds that apply to the beat presented after this edge.
    always_comb begin
        bound_x_d = wm1_q;
        bound_y_d = hm1_q;
        if (state_q == ST_IDLE) begin
            bound_x_d = width_m1;
            bound_y_d = height_m1;
        end
    end

    // Edge flags and steps for the next beat, from the counters' next values.
    always_comb begin
        last_d   = (x_nxt == bound_x_d) && (y_nxt == bound_y_d);
        step_x_d = COORD_W'(STEP_ONE);
        step_y_d = COORD_W'(STEP_ONE);
`ifdef INTERP_COORD_GEN_EDGE_CLAMP_EN
        if (x_nxt == bound_x_d) begin
            step_x_d = COORD_W'(STEP_ZERO);
        end
        if (y_nxt == bound_y_d) begin
            step_y_d = COORD_W'(STEP_ZERO);
        end
`endif
    end

    // Frame FSM with all handshake and beat outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wm1_q    <= '0;
            hm1_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            step_x_q <= '0;
            step_y_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q  <= ST_RUN;
                        wm1_q    <= width_m1;
                        hm1_q    <= height_m1;
                        busy_q   <= 1'b1;
                        valid_q  <= 1'b1;
                        last_q   <= last_d;
                        step_x_q <= step_x_d;
                        step_y_q <= step_y_d;
                    end
                end
                ST_RUN: begin
                    if (frame_end) begin
                        state_q  <= ST_DONE;
                        valid_q  <= 1'b0;
                        last_q   <= 1'b0;
                        step_x_q <= '0;
                        step_y_q <= '0;
                        done_q   <= 1'b1;
                    end else if (xfer) begin
                        last_q   <= last_d;
                        step_x_q <= step_x_d;
                        step_y_q <= step_y_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = valid_q;
    assign x         = x_cnt;
    assign y         = y_cnt;
    assign step_x    = step_x_q;
    assign step_y    = step_y_q;
    assign last      = last_q;

endmodule
